// File: rtl/gray_counter_param.sv
// gray_counter_param: parametrised, registered Gray-code counter.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         count enable, one step per clock while high
//   up         direction (1 = increment, 0 = decrement), used only when en=1
//   load       parallel load strobe          (only with GRAY_CNT_LOAD_EN)
//   load_gray  Gray-coded value to load      (only with GRAY_CNT_LOAD_EN)
//   gray_count registered Gray count
//   bin_count  registered binary equivalent of gray_count
//   tc         registered terminal-count pulse (boundary step on previous edge)
//
// Parameters: WIDTH (>=2), SATURATE (0 wrap / 1 hold at the ends),
//             RST_VAL (binary reset value).
// Optional feature macro: GRAY_CNT_LOAD_EN adds the parallel load path.
//
// bin_count is the true state. Both outputs are loaded from the same
// combinational next value, so they always correspond and neither is
// decoded from the other after the flops.
module gray_counter_param #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0,
  parameter int RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
`ifdef GRAY_CNT_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
`endif
  output logic [WIDTH-1:0] gray_count,
  output logic [WIDTH-1:0] bin_count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

  logic [WIDTH-1:0] bin_nxt;
  logic             tc_nxt;
  logic             boundary;

`ifdef GRAY_CNT_LOAD_EN
  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  logic [WIDTH-1:0] load_bin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_g2b
    assign load_bin[i] = ^load_gray[WIDTH-1:i];
  end
`endif

  // A step that would cross an end of the range in the current direction.
  assign boundary = up ? (bin_count == '1) : (bin_count == '0);

  always_comb begin
    bin_nxt = bin_count;
    tc_nxt  = 1'b0;
`ifdef GRAY_CNT_LOAD_EN
    if (load) begin
      bin_nxt = load_bin;
    end else
`endif
    if (en) begin
      tc_nxt = boundary;
      // Saturating mode parks at the end; wrap mode lets the modulo
      // arithmetic carry it around, which is a single Gray bit flip.
      if (!(SATURATE && boundary)) begin
        bin_nxt = up ? bin_count + 1'b1 : bin_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_count  <= RST_BIN;
      gray_count <= RST_GRAY;
      tc         <= 1'b0;
    end else begin
      bin_count  <= bin_nxt;
      gray_count <= bin_nxt ^ (bin_nxt >> 1);
      tc         <= tc_nxt;
    end
  end

endmodule

// File: tb/tb_gray_counter_param.sv
// Scoreboard bench for gray_counter_param. Three instances share one clock:
//   d0: WIDTH=4 wrap, d1: WIDTH=4 saturate, d2: WIDTH=8 wrap RST_VAL=200.
// Stimulus tasks push expected outputs into a queue; a monitor process pops
// and compares after each clock edge (or after an explicit async sample).
module tb_gray_counter_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   en_v [3];
  bit   up_v [3];
  logic       load = 1'b0;
  logic [3:0] load_gray = 4'h0;

  logic [3:0] g0, b0, g1, b1;
  logic [7:0] g2, b2;
  logic       t0, t1, t2;

  always #5 clk = ~clk;

  gray_counter_param #(.WIDTH(4), .SATURATE(1'b0), .RST_VAL(0)) d0 (
    .clk(clk), .rst_n(rst_n), .en(en_v[0]), .up(up_v[0]),
`ifdef GRAY_CNT_LOAD_EN
    .load(load), .load_gray(load_gray),
`endif
    .gray_count(g0), .bin_count(b0), .tc(t0));

  gray_counter_param #(.WIDTH(4), .SATURATE(1'b1), .RST_VAL(0)) d1 (
    .clk(clk), .rst_n(rst_n), .en(en_v[1]), .up(up_v[1]),
`ifdef GRAY_CNT_LOAD_EN
    .load(1'b0), .load_gray(4'h0),
`endif
    .gray_count(g1), .bin_count(b1), .tc(t1));

  gray_counter_param #(.WIDTH(8), .SATURATE(1'b0), .RST_VAL(200)) d2 (
    .clk(clk), .rst_n(rst_n), .en(en_v[2]), .up(up_v[2]),
`ifdef GRAY_CNT_LOAD_EN
    .load(1'b0), .load_gray(8'h00),
`endif
    .gray_count(g2), .bin_count(b2), .tc(t2));

  typedef struct {
    int         id;
    logic [7:0] gray;
    logic [7:0] bin;
    logic       tc;
    bit         one;   // also require exactly one Gray bit to have flipped
    string      name;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] prev_g [3];
  event       sample_ev;

  // Hand-computed 4-bit Gray table indexed by binary value.
  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  task automatic push_exp(input int id, input logic [7:0] eb, input logic [7:0] eg,
                          input logic et, input bit one, input string nm);
    exp_t e;
    e.id = id; e.bin = eb; e.gray = eg; e.tc = et; e.one = one; e.name = nm;
    q.push_back(e);
  endtask

  task automatic step(input int id, input bit e, input bit u, input logic [7:0] eb,
                      input logic [7:0] eg, input logic et, input bit one, input string nm);
    @(negedge clk);
    en_v = '{0, 0, 0};
    en_v[id] = e;
    up_v[id] = u;
    @(posedge clk);
    #1 push_exp(id, eb, eg, et, one, nm);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    en_v = '{0, 0, 0};
    rst_n = 1'b0;
    #1;
    push_exp(0, 8'd0,   8'h00, 1'b0, 1'b0, "reset_d0");
    push_exp(1, 8'd0,   8'h00, 1'b0, 1'b0, "reset_d1");
    push_exp(2, 8'd200, 8'hAC, 1'b0, 1'b0, "reset_d2");
    -> sample_ev;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t       e;
    logic [7:0] ag, ab;
    logic       at;
    forever begin
      @(posedge clk or sample_ev);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.id)
          0:       begin ag = {4'h0, g0}; ab = {4'h0, b0}; at = t0; end
          1:       begin ag = {4'h0, g1}; ab = {4'h0, b1}; at = t1; end
          default: begin ag = g2;         ab = b2;         at = t2; end
        endcase
        checks++;
        if (ag !== e.gray || ab !== e.bin || at !== e.tc) begin
          failures++;
          $display("FAIL %s d%0d: got gray=%h bin=%0d tc=%b, want gray=%h bin=%0d tc=%b",
                   e.name, e.id, ag, ab, at, e.gray, e.bin, e.tc);
        end
        if (e.one) begin
          checks++;
          if ($countones(ag ^ prev_g[e.id]) != 1) begin
            failures++;
            $display("FAIL %s_onebit d%0d: got gray %h -> %h, want one bit change",
                     e.name, e.id, prev_g[e.id], ag);
          end
        end
        prev_g[e.id] = ag;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    rst_pulse();

    // Wrap up-count, 17 steps: 1..15, 0 (tc), 1
    for (int k = 1; k <= 17; k++) begin
      b = 8'(k % 16);
      step(0, 1'b1, 1'b1, b, {4'h0, gtab[b[3:0]]}, (k == 16), 1'b1, "wrap_up");
    end
    step(0, 1'b0, 1'b1, 8'd1, 8'h01, 1'b0, 1'b0, "idle_after_wrap");

    // Wrap down-count
    rst_pulse();
    step(0, 1'b1, 1'b0, 8'd15, 8'h08, 1'b1, 1'b1, "wrap_dn");
    step(0, 1'b1, 1'b0, 8'd14, 8'h09, 1'b0, 1'b1, "wrap_dn");
    step(0, 1'b1, 1'b0, 8'd13, 8'h0B, 1'b0, 1'b1, "wrap_dn");

    // Saturate
    rst_pulse();
    for (int k = 1; k <= 15; k++)
      step(1, 1'b1, 1'b1, 8'(k), {4'h0, gtab[k]}, 1'b0, 1'b1, "sat_up");
    for (int k = 0; k < 3; k++)
      step(1, 1'b1, 1'b1, 8'd15, 8'h08, 1'b1, 1'b0, "sat_hold");
    step(1, 1'b1, 1'b0, 8'd14, 8'h09, 1'b0, 1'b1, "sat_dn");

    // Enable hold then asynchronous reset between edges
    rst_pulse();
    for (int k = 1; k <= 5; k++)
      step(0, 1'b1, 1'b1, 8'(k), {4'h0, gtab[k]}, 1'b0, 1'b1, "en_up");
    for (int k = 0; k < 4; k++)
      step(0, 1'b0, k[0], 8'd5, 8'h07, 1'b0, 1'b0, "en_hold");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    push_exp(0, 8'd0,   8'h00, 1'b0, 1'b0, "async_rst_d0");
    push_exp(2, 8'd200, 8'hAC, 1'b0, 1'b0, "async_rst_d2");
    -> sample_ev;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef GRAY_CNT_LOAD_EN
    // Load wins over en on the same edge
    rst_pulse();
    @(negedge clk);
    load = 1'b1; load_gray = 4'b1101; en_v[0] = 1'b1; up_v[0] = 1'b1;
    @(posedge clk);
    #1 push_exp(0, 8'd9, 8'h0D, 1'b0, 1'b0, "load");
    @(negedge clk);
    load = 1'b0;
    step(0, 1'b1, 1'b1, 8'd10, 8'h0F, 1'b0, 1'b1, "post_load");
`endif

    // WIDTH=8 sweep from 200, 256 up-steps
    rst_pulse();
    for (int k = 1; k <= 256; k++) begin
      b = 8'((200 + k) % 256);
      step(2, 1'b1, 1'b1, b, b ^ (b >> 1), (b == 8'd0), 1'b1, "sweep");
    end

    @(negedge clk);
    en_v = '{0, 0, 0};
    repeat (3) @(posedge clk);
    #5;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
